sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM controller port (edge-triggered rd/wr, level busy, 16-bit dout) among
//  NPORTS requesters (e.g. CPU, DMA/PPU fetch, audio RAM). Each requester uses a level req / one-cycle
//  ack handshake. The arbiter serialises requests, generates the rd/wr edges the controller needs,
//  waits out busy and returns read data. It sits between the core buses and the sdram controller.
// PARAMETERS
//  NPORTS     3   number of requester ports (2..4)
//  PRIO0      1   1: port 0 has absolute priority over the others; 0: pure round-robin over all ports
//  AW         25  byte address width (matches controller addr)
// PORTS
//  clk          in   1          controller clock, same as the sdram controller
//  init_n       in   1          asynchronous active-low reset
//  req          in   NPORTS     per-port request level; held until ack
//  we           in   NPORTS     per-port 1=write 0=read; stable while req high
//  word         in   NPORTS     per-port 1=16-bit access, 0=byte access
//  addr         in   NPORTS*AW  per-port byte address, port i at [i*AW +: AW]
//  wdata        in   NPORTS*16  per-port write data, port i at [i*16 +: 16]
//  ack          out  NPORTS     one-cycle completion pulse to the granted port
//  rdata        out  16         read data; valid in the ack cycle of a read
//  grant_id     out  2          index of the port currently or last served
//  sd_addr      out  AW         to controller addr
//  sd_din       out  16         to controller din
//  sd_word      out  1          to controller word
//  sd_rd        out  1          to controller rd (rising edge starts a read)
//  sd_wr        out  1          to controller wr (rising edge starts a write)
//  sd_dout      in   16         from controller dout
//  sd_busy      in   1          from controller busy
// BEHAVIOUR
//  Reset (init_n low, async): state=IDLE, ack=0, sd_rd=sd_wr=0, rdata=0, grant_id=0, rr pointer=0,
//   sd_addr/sd_din/sd_word=0. Reset mid-transfer abandons it; no ack is issued for it.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if any req, pick winner; register addr/wdata/word/we of winner onto sd_*; grant_id=winner;
//   assert sd_rd (we=0) or sd_wr (we=1) on the same edge; go ISSUE. No req: stay, outputs hold.
//  Selection: PRIO0=1 and req[0] -> port 0. Otherwise round-robin starting at rr+1 (mod NPORTS),
//   first port with req wins; rr <= winner on grant. Port 0 grants under PRIO0 do not move rr.
//  ISSUE: hold sd_rd/sd_wr high and sd_* stable until sd_busy=1 (controller accepts only in its idle
//   state and after init, so wait is unbounded); on sd_busy=1 drop sd_rd/sd_wr, go WAIT.
//  WAIT: sd_rd/sd_wr low; stay until sd_busy=0; then go DONE.
//  DONE: ack[grant_id]=1 for exactly this cycle; rdata<=sd_dout if read (rdata unchanged on write);
//   go IDLE. rd/wr are low >=2 cycles between accesses so the controller always sees a fresh edge.
//  sd_addr/sd_din/sd_word held from IDLE grant until the next grant (controller samples them late).
//  Requester rule: drop req on the edge that sees ack; a req still high in IDLE is a new request.
//  Changing we/addr/word/wdata while req high and unacked is illegal (undefined result).
//  Minimum occupancy: IDLE+ISSUE(>=2)+WAIT+DONE; back-to-back same-port requests still rearbitrate.
//  Requests raised during ISSUE/WAIT/DONE wait; none are dropped.
// TESTING
//  1 Reset release, controller in init (busy never set): req[1] read -> sd_rd held high, no ack
//    until controller enters normal mode; then ack[1] once, rdata = model word at addr.
//  2 Write port0 addr=0x000100 wdata=0xBEEF word=1, then read same -> rdata=0xBEEF, 1 ack each.
//  3 Byte write port2 addr=0x000101 data=0x5A, then word read 0x000100 -> rdata=0x5AEF.
//  4 PRIO0=0, req=3'b111 held continuously -> grants rotate 1,2,0,1,2,0; each port acked in turn.
//  5 PRIO0=1, req[0] reasserted right after each ack, req[2] pending -> port0 wins each IDLE;
//    req[2] served only when req[0] low in IDLE.
//  6 init_n pulsed low during WAIT -> ack=0, sd_rd=sd_wr=0 immediately; pending reqs served after.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Requester-side bus of the SDRAM arbiter: per-port level request, one-cycle ack, shared read data.
interface sdram_arbiter_if #(
  parameter int unsigned NPORTS = 3,
  parameter int unsigned AW     = 25
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS-1:0]    word;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*16-1:0] wdata;
  logic [NPORTS-1:0]    ack;
  logic [15:0]          rdata;
  logic [1:0]           grant_id;

  // Requesters drive the request fields and observe completion.
  modport master (
    output req, we, word, addr, wdata,
    input  ack, rdata, grant_id
  );

  // The arbiter consumes requests and reports completion.
  modport slave (
    input  req, we, word, addr, wdata,
    output ack, rdata, grant_id
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Serialises NPORTS requesters onto one edge-triggered SDRAM controller port.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE so rd/wr always present a fresh edge.
module sdram_arbiter #(
  parameter int unsigned NPORTS = 3,
  parameter int unsigned PRIO0  = 1,
  parameter int unsigned AW     = 25
) (
  input  logic          clk,
  input  logic          init_n,
  sdram_arbiter_if.slave bus,
  output logic [AW-1:0] sd_addr,
  output logic [15:0]   sd_din,
  output logic          sd_word,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic [15:0]   sd_dout,
  input  logic          sd_busy
);

  localparam int unsigned MAXP = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [1:0]        rr, rr_nxt;
  logic [1:0]        grant, grant_nxt;
  logic [NPORTS-1:0] ack, ack_nxt;
  logic [15:0]       rdata, rdata_nxt;
  logic              op_wr, op_wr_nxt;
  logic [AW-1:0]     sd_addr_nxt;
  logic [15:0]       sd_din_nxt;
  logic              sd_word_nxt, sd_rd_nxt, sd_wr_nxt;

  logic [MAXP-1:0]   req_p, we_p, word_p;
  logic [AW-1:0]     addr_a  [MAXP];
  logic [15:0]       wdata_a [MAXP];

  logic [1:0]        win, cand;
  logic              win_vld, prio_hit;

  assign bus.ack      = ack;
  assign bus.rdata    = rdata;
  assign bus.grant_id = grant;

  // Unpack the flat per-port request fields into small indexable arrays.
  always_comb begin
    req_p  = MAXP'(bus.req);
    we_p   = MAXP'(bus.we);
    word_p = MAXP'(bus.word);
    for (int i = 0; i < int'(MAXP); i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    for (int i = 0; i < int'(NPORTS); i++) begin
      addr_a[i]  = bus.addr[i*AW +: AW];
      wdata_a[i] = bus.wdata[i*16 +: 16];
    end
  end

  // Winner selection: optional absolute priority for port 0, else round-robin from rr+1.
  always_comb begin
    win      = '0;
    cand     = '0;
    win_vld  = 1'b0;
    prio_hit = 1'b0;
    if ((PRIO0 != 0) && req_p[0]) begin
      win_vld  = 1'b1;
      prio_hit = 1'b1;
    end else begin
      for (int k = 1; k <= int'(NPORTS); k++) begin
        cand = 2'((int'(rr) + k) % int'(NPORTS));
        if (!win_vld && req_p[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic; every registered output holds by default.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    grant_nxt   = grant;
    ack_nxt     = '0;
    rdata_nxt   = rdata;
    op_wr_nxt   = op_wr;
    sd_addr_nxt = sd_addr;
    sd_din_nxt  = sd_din;
    sd_word_nxt = sd_word;
    sd_rd_nxt   = sd_rd;
    sd_wr_nxt   = sd_wr;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          sd_addr_nxt = addr_a[win];
          sd_din_nxt  = wdata_a[win];
          sd_word_nxt = word_p[win];
          sd_wr_nxt   = we_p[win];
          sd_rd_nxt   = !we_p[win];
          op_wr_nxt   = we_p[win];
          grant_nxt   = win;
          if (!prio_hit) rr_nxt = win;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sd_busy) begin
          sd_rd_nxt = 1'b0;
          sd_wr_nxt = 1'b0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!sd_busy) begin
          ack_nxt = NPORTS'(1) << grant;
          if (!op_wr) rdata_nxt = sd_dout;
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state   <= S_IDLE;
      rr      <= '0;
      grant   <= '0;
      ack     <= '0;
      rdata   <= '0;
      op_wr   <= 1'b0;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_word <= 1'b0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      grant   <= grant_nxt;
      ack     <= ack_nxt;
      rdata   <= rdata_nxt;
      op_wr   <= op_wr_nxt;
      sd_addr <= sd_addr_nxt;
      sd_din  <= sd_din_nxt;
      sd_word <= sd_word_nxt;
      sd_rd   <= sd_rd_nxt;
      sd_wr   <= sd_wr_nxt;
    end
  end

endmodule
